bus_cycle_decoder: RTL

//   Samples the asynchronous 6809 bus (E, Q, R/W, A[15:0]) into the FPGA clock domain.

---
 rtl/bus_cycle_decoder_pkg.sv | 17 +
 rtl/bus_cycle_decoder_edge_sync.sv | 27 ++
 rtl/bus_cycle_decoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/bus_cycle_decoder_pkg.sv
// bus_cycle_decoder_pkg: FSM state encoding, address window compare helpers and bank register location
package bus_cycle_decoder_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, ACTIVE} state_t;
  localparam int unsigned BANK_REG_FROM_TOP = 1;
  function automatic logic in_io(input logic [15:0] a, input logic [15:0] base, input int log2);
    return (a >> log2) == (base >> log2);
  endfunction
  function automatic logic in_rom(input logic [15:0] a, input logic [15:0] base);
    return a >= base;
  endfunction
  function automatic logic in_sram(input logic [15:0] a, input logic [15:0] top);
    return a <= top;
  endfunction
  function automatic logic [15:0] bank_addr(input logic [15:0] base, input int log2);
    return base + 16'(1 << log2) - 16'(BANK_REG_FROM_TOP);
  endfunction
endpackage

// File: rtl/bus_cycle_decoder_edge_sync.sv
// bus_cycle_decoder_edge_sync: multi-flop synchronizer for a raw 6809 clock with registered rise/fall pulses
// Ports: clk, rst_n (async active-low); d raw input; rise/fall one-clk pulses on synchronized edges.
// Flops reset to 1 so an input already high at reset release is not seen as a rise.
module bus_cycle_decoder_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chain <= '1;
      prev <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev <= chain[STAGES-1];
      rise <= chain[STAGES-1] & ~prev;
      fall <= ~chain[STAGES-1] & prev;
    end
endmodule

// File: rtl/bus_cycle_decoder.sv
// bus_cycle_decoder: samples the 6809 bus, tracks cycle phases, latches address/R-W and drives registered chip selects
// Ports: i_clk, i_rst_n (async active-low); i_E/i_Q/i_RW/i_addr/i_data raw 6809 bus;
//   o_sram_ce/o_rom_ce/o_io_ce registered selects (high only in ACTIVE); o_RW/o_addr_lat latched at cycle start;
//   o_cycle_start/o_cycle_end one-clk pulses; o_bus_timeout sticky stall flag; o_bank SRAM bank register.
// Optional macro BANK_REG_EN adds the bank register at the top byte of the I/O window; otherwise o_bank is 0.
module bus_cycle_decoder
  import bus_cycle_decoder_pkg::*;
#(
  parameter logic [15:0] SRAM_TOP     = 16'h7FFF,
  parameter logic [15:0] IO_BASE      = 16'hA000,
  parameter int          IO_SIZE_LOG2 = 4,
  parameter logic [15:0] ROM_BASE     = 16'hC000,
  parameter int          SYNC_STAGES  = 2,
  parameter int          TIMEOUT_CYC  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_E,
  input  logic        i_Q,
  input  logic        i_RW,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  output logic        o_sram_ce,
  output logic        o_rom_ce,
  output logic        o_io_ce,
  output logic        o_RW,
  output logic [15:0] o_addr_lat,
  output logic        o_cycle_start,
  output logic        o_cycle_end,
  output logic        o_bus_timeout,
  output logic [3:0]  o_bank
);
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT_CYC);
  state_t state, nxt;
  logic e_rise, e_fall, q_rise, unused_q_fall;
  logic start, close, abort, active_nxt;
  logic io_hit, rom_hit, sram_hit;
  logic [7:0] cnt;
  logic [15:0] dec_addr;
  bus_cycle_decoder_edge_sync #(.STAGES(SYNC_STAGES)) e_sync (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_E), .rise(e_rise), .fall(e_fall)
  );
  bus_cycle_decoder_edge_sync #(.STAGES(SYNC_STAGES)) q_sync (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_Q), .rise(q_rise), .fall(unused_q_fall)
  );
  // E rise takes precedence in IDLE so a simultaneous Q/E rise goes straight to ACTIVE;
  // in ACTIVE an E fall beats a coincident timeout.
  always_comb begin
    nxt = state;
    start = 1'b0;
    close = 1'b0;
    abort = 1'b0;
    unique case (state)
      IDLE: begin
        start = e_rise | q_rise;
        nxt = e_rise ? ACTIVE : q_rise ? ADDR : IDLE;
      end
      ADDR: begin
        abort = cnt == TO_CNT;
        nxt = abort ? IDLE : e_rise ? ACTIVE : ADDR;
      end
      ACTIVE: begin
        close = e_fall;
        abort = !e_fall && cnt == TO_CNT;
        nxt = (close || abort) ? IDLE : ACTIVE;
      end
      default: nxt = IDLE;
    endcase
  end
  // Decode the address being latched on the start clock, the held latch afterwards.
  assign dec_addr = start ? i_addr : o_addr_lat;
  assign io_hit = in_io(dec_addr, IO_BASE, IO_SIZE_LOG2);
  assign rom_hit = !io_hit && in_rom(dec_addr, ROM_BASE);
  assign sram_hit = !io_hit && !rom_hit && in_sram(dec_addr, SRAM_TOP);
  assign active_nxt = nxt == ACTIVE;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= 8'd0;
      o_addr_lat <= 16'h0000;
      o_RW <= 1'b1;
      o_sram_ce <= 1'b0;
      o_rom_ce <= 1'b0;
      o_io_ce <= 1'b0;
      o_cycle_start <= 1'b0;
      o_cycle_end <= 1'b0;
      o_bus_timeout <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= start ? 8'd0 : (state != IDLE) ? cnt + 8'd1 : cnt;
      o_addr_lat <= start ? i_addr : o_addr_lat;
      o_RW <= start ? i_RW : o_RW;
      o_sram_ce <= active_nxt & sram_hit;
      o_rom_ce <= active_nxt & rom_hit;
      o_io_ce <= active_nxt & io_hit;
      o_cycle_start <= start;
      o_cycle_end <= close;
      o_bus_timeout <= start ? 1'b0 : abort ? 1'b1 : o_bus_timeout;
    end
`ifdef BANK_REG_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_bank <= 4'h0;
    else o_bank <= (close && !o_RW && o_io_ce && o_addr_lat == bank_addr(IO_BASE, IO_SIZE_LOG2)) ? i_data[3:0] : o_bank;
`else
  logic unused_data;
  assign unused_data = ^i_data;
  assign o_bank = 4'h0;
`endif
endmodule
